// File: rtl/shift_sequencer.sv
// ============================================================================
// Module   : shift_sequencer
// Brief    : Multi-cycle 32-bit SRL/SLL/SRA unit, one barrel level per clock.
//            Optional early exit via macro SHIFT_SEQ_EARLY_EXIT_EN.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module shift_sequencer #(
  parameter int WIDTH = 32,
  parameter int SHW   = 5
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] data_in,
  input  logic [SHW-1:0]   shamt,
  input  logic [1:0]       op,
  output logic             ready,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result
);

  if (WIDTH != 32 || SHW != 5) begin : g_bad_param
    $error("shift_sequencer supports only WIDTH=32, SHW=5");
  end

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  state_t           r_state;
  state_t           w_next;
  logic [2:0]       r_stage;
  logic [WIDTH-1:0] r_work;
  logic [WIDTH-1:0] r_result;
  logic [SHW-1:0]   r_shamt;
  logic [1:0]       r_op;
  logic [WIDTH-1:0] w_level;
  logic [4:0]       w_k;
  logic             w_accept;
  logic             w_last;

  assign w_accept = start && ((r_state == S_IDLE) || (r_state == S_DONE));
  assign w_k      = 5'd1 << r_stage;

`ifdef SHIFT_SEQ_EARLY_EXIT_EN
  // Leave once no latched shamt bit above the level being applied remains set.
  assign w_last = (r_stage == 3'd4) || ((r_shamt >> (r_stage + 3'd1)) == '0);
`else
  assign w_last = (r_stage == 3'd4);
`endif

  always_comb begin
    w_level = r_work;
    if (r_shamt[r_stage]) begin
      case (r_op)
        2'b00:   w_level = r_work >> w_k;
        2'b01:   w_level = r_work << w_k;
        2'b10:   w_level = $unsigned($signed(r_work) >>> w_k);
        default: w_level = r_work;
      endcase
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  w_next = start ? S_SHIFT : S_IDLE;
      S_SHIFT: w_next = w_last ? S_DONE : S_SHIFT;
      S_DONE:  w_next = start ? S_SHIFT : S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= S_IDLE;
      r_stage  <= 3'd0;
      r_work   <= '0;
      r_shamt  <= '0;
      r_op     <= 2'b00;
      r_result <= '0;
    end else begin
      r_state <= w_next;
      if (w_accept) begin
        r_work  <= data_in;
        r_shamt <= shamt;
        r_op    <= op;
        r_stage <= 3'd0;
      end else if (r_state == S_SHIFT) begin
        r_work  <= w_level;
        r_stage <= r_stage + 3'd1;
        if (w_last) begin
          r_result <= w_level;
        end
      end
    end
  end

  // Flags decode the state register only, so no input reaches an output.
  assign ready  = (r_state == S_IDLE) || (r_state == S_DONE);
  assign busy   = (r_state == S_SHIFT);
  assign done   = (r_state == S_DONE);
  assign result = r_result;

endmodule

`default_nettype wire

// File: tb/tb_shift_sequencer.sv
// ============================================================================
// Module   : tb_shift_sequencer
// Brief    : Directed plus random stimulus against an arithmetic shift model.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_shift_sequencer;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [31:0] data_in;
  logic [4:0]  shamt;
  logic [1:0]  op;
  logic        ready;
  logic        busy;
  logic        done;
  logic [31:0] result;

  int          checks;
  int          errors;
  logic [31:0] last_exp;

  shift_sequencer #(.WIDTH(32), .SHW(5)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .start   (start),
    .data_in (data_in),
    .shamt   (shamt),
    .op      (op),
    .ready   (ready),
    .busy    (busy),
    .done    (done),
    .result  (result)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] ref_shift(input logic [31:0] d, input logic [4:0] sh,
                                            input logic [1:0] o);
    case (o)
      2'b00:   return d >> sh;
      2'b01:   return d << sh;
      2'b10:   return $unsigned($signed(d) >>> sh);
      default: return d;
    endcase
  endfunction

  function automatic int exp_lat(input logic [4:0] sh);
    int lat;
`ifdef SHIFT_SEQ_EARLY_EXIT_EN
    lat = 1;
    for (int b = 0; b < 5; b++) if (sh[b]) lat = b + 1;
`else
    lat = 5;
`endif
    return lat;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Called at a negedge; returns at the negedge of the DONE cycle.
  task automatic run_op(input logic [31:0] d, input logic [4:0] sh, input logic [1:0] o,
                        input bit noise);
    int lat;
    lat      = exp_lat(sh);
    last_exp = ref_shift(d, sh, o);
    start    = 1'b1;
    data_in  = d;
    shamt    = sh;
    op       = o;
    @(posedge clk);
    @(negedge clk);
    for (int n = 0; n < lat; n++) begin
      if (n > 0) @(negedge clk);
      chk("busy_in_shift", {31'd0, busy}, 32'd1);
      chk("done_in_shift", {31'd0, done}, 32'd0);
      start   = noise;
      data_in = 32'h12345678;
      shamt   = 5'd8;
      op      = 2'b00;
    end
    @(negedge clk);
    start = 1'b0;
    chk("done_pulse", {31'd0, done}, 32'd1);
    chk("ready_in_done", {31'd0, ready}, 32'd1);
    chk("busy_in_done", {31'd0, busy}, 32'd0);
    chk("result", result, last_exp);
  endtask

  task automatic idle_check();
    @(negedge clk);
    chk("idle_done", {31'd0, done}, 32'd0);
    chk("idle_busy", {31'd0, busy}, 32'd0);
    chk("idle_ready", {31'd0, ready}, 32'd1);
    chk("idle_result_held", result, last_exp);
  endtask

  initial begin
    checks   = 0;
    errors   = 0;
    last_exp = 32'd0;
    rst_n    = 1'b0;
    start    = 1'b0;
    data_in  = 32'd0;
    shamt    = 5'd0;
    op       = 2'b00;

    #12;
    chk("rst_ready", {31'd0, ready}, 32'd1);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_done", {31'd0, done}, 32'd0);
    chk("rst_result", result, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    run_op(32'h80000000, 5'd31, 2'b00, 1'b0);
    idle_check();
    run_op(32'h00000001, 5'd5, 2'b01, 1'b0);
    idle_check();
    run_op(32'h80000000, 5'd4, 2'b10, 1'b0);
    idle_check();
    run_op(32'h80000000, 5'd31, 2'b10, 1'b0);
    idle_check();
    run_op(32'hDEADBEEF, 5'd0, 2'b00, 1'b0);
    idle_check();

    // Start held during SHIFT must be ignored; start during DONE is accepted.
    run_op(32'hA5A5A5A5, 5'd3, 2'b01, 1'b1);
    idle_check();
    run_op(32'hF0F0F0F0, 5'd12, 2'b10, 1'b1);
    run_op(32'h12345678, 5'd8, 2'b00, 1'b0);
    idle_check();
    run_op(32'hA5A5A5A5, 5'd31, 2'b11, 1'b0);
    idle_check();

    // Asynchronous abort at stage 2 of SLL 0x0000FFFF by 16.
    start   = 1'b1;
    data_in = 32'h0000FFFF;
    shamt   = 5'd16;
    op      = 2'b01;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("abort_result", result, 32'd0);
    chk("abort_busy", {31'd0, busy}, 32'd0);
    chk("abort_done", {31'd0, done}, 32'd0);
    chk("abort_ready", {31'd0, ready}, 32'd1);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      chk("post_abort_done", {31'd0, done}, 32'd0);
    end
    chk("post_abort_ready", {31'd0, ready}, 32'd1);
    last_exp = 32'd0;

    for (int i = 0; i < 40; i++) begin
      run_op($urandom, 5'($urandom_range(31, 0)), 2'($urandom_range(3, 0)),
             1'($urandom_range(1, 0)));
      if ($urandom_range(1, 0) == 1) idle_check();
    end
    idle_check();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
